// File: rtl/fft_pkg.sv
// fft_pkg: shared FFT constants and the butterfly sequencer state type
package fft_pkg;
  localparam int FFT_N_LOG2 = 5;
  localparam int FFT_N = 32;
  localparam int FFT_BFLY_PER_STAGE = 16;
  typedef enum logic [1:0] {IDLE, RUN, ADV, DONE} state_t;
endpackage

// File: rtl/fft_bfly_addr_calc.sv
// fft_bfly_addr_calc: combinational (stage, k) to butterfly operand and twiddle addresses
module fft_bfly_addr_calc
  import fft_pkg::*;
#(
  parameter int N_LOG2 = FFT_N_LOG2,
  parameter int ADDR_W = N_LOG2,
  parameter int TW_W = N_LOG2 - 1
) (
  input  logic [2:0]        stage,
  input  logic [N_LOG2-2:0] k,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [TW_W-1:0]   tw_addr
);
  logic [ADDR_W-1:0] h, pos, grp;
  assign h = ADDR_W'(1) << stage;
  assign pos = ADDR_W'(k) & (h - ADDR_W'(1));
  assign grp = ADDR_W'(k) >> stage;
  assign addr_a = (grp << (stage + 3'd1)) + pos;
  assign addr_b = addr_a + h;
  assign tw_addr = TW_W'(pos << (3'(N_LOG2 - 1) - stage));
endmodule

// File: rtl/fft_bfly_addr_gen.sv
// fft_bfly_addr_gen: per-stage butterfly address sequencer driving the external stage counter
module fft_bfly_addr_gen
  import fft_pkg::*;
#(
  parameter int N_LOG2 = FFT_N_LOG2,
  parameter int ADDR_W = N_LOG2,
  parameter int TW_W = N_LOG2 - 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              ready,
  input  logic [2:0]        stage,
  input  logic              stage_last,
  output logic              stage_adv,
  output logic              stage_rst_n,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic [TW_W-1:0]   tw_addr,
  output logic              done
);
  state_t state, state_nx;
  logic [N_LOG2-2:0] k, k_nx;
  logic hs;
  logic [2:0] calc_stage;
  logic [ADDR_W-1:0] a_nx, b_nx;
  logic [TW_W-1:0] tw_nx;
  assign hs = out_valid & out_ready;
  assign ready = state == IDLE;
  assign out_valid = state == RUN;
  assign done = state == DONE;
  assign stage_rst_n = state == RUN || state == ADV;
  assign stage_adv = hs && k == '1;
  // a new transform always begins at stage 0, even while the counter is still clearing
  assign calc_stage = ready ? 3'd0 : stage;
  fft_bfly_addr_calc #(.N_LOG2(N_LOG2), .ADDR_W(ADDR_W), .TW_W(TW_W)) u_calc (
    .stage(calc_stage),
    .k(k_nx),
    .addr_a(a_nx),
    .addr_b(b_nx),
    .tw_addr(tw_nx)
  );
  // next state and next butterfly index
  always_comb begin
    state_nx = state;
    k_nx = '0;
    case (state)
      IDLE: state_nx = start ? RUN : IDLE;
      RUN: begin
        k_nx = hs ? k + 1'b1 : k;
        state_nx = stage_adv ? ADV : RUN;
      end
      ADV: state_nx = stage_last ? DONE : RUN;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  // state, index and address registers; addresses load only when entering or staying in RUN
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      k <= '0;
      addr_a <= '0;
      addr_b <= '0;
      tw_addr <= '0;
    end else begin
      state <= state_nx;
      k <= k_nx;
      if (state_nx == RUN) begin
        addr_a <= a_nx;
        addr_b <= b_nx;
        tw_addr <= tw_nx;
      end
    end
  end
endmodule
